// File: rtl/npc_gen.sv
// Program-counter generator: holds the fetch PC and selects the next PC from
// exception entry, jr, J-type, branch or sequential sources, with optional delay slot.
module npc_gen #(
    parameter int          ADDR_W     = 32,
    parameter logic [31:0] RESET_VEC  = 32'h0040_0000,
    parameter logic [31:0] EXC_VEC    = 32'h0040_0004,
    parameter int          DELAY_SLOT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              br_taken,
    input  logic [15:0]       br_offset,
    input  logic              j_req,
    input  logic [25:0]       j_index,
    input  logic              jr_req,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              exc_req,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              slot_pending,
    output logic              jr_misalign
);

    typedef enum logic {
        RUN  = 1'b0,
        SLOT = 1'b1
    } state_e;

    localparam logic [ADDR_W-1:0] RST_PC   = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] EXC_PC   = ADDR_W'(EXC_VEC);
    // Bits above the 256 MB segment that a J-type jump keeps from pc_plus4.
    localparam logic [ADDR_W-1:0] SEG_MASK = ~ADDR_W'(28'hFFF_FFFF);

    // Branch: signed word offset, scaled by 4, added modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] b_target(input logic [ADDR_W-1:0] pc4,
                                                   input logic [15:0]       off);
        logic signed [ADDR_W-1:0] disp;
        disp = {{(ADDR_W-18){off[15]}}, off, 2'b00};
        return pc4 + $unsigned(disp);
    endfunction

    // J-type: full-width result, the shifted index is never truncated.
    function automatic logic [ADDR_W-1:0] j_target(input logic [ADDR_W-1:0] pc4,
                                                   input logic [25:0]       idx);
        return (pc4 & SEG_MASK) | ADDR_W'({idx, 2'b00});
    endfunction

    function automatic logic [ADDR_W-1:0] r_target(input logic [ADDR_W-1:0] t);
        return {t[ADDR_W-1:2], 2'b00};
    endfunction

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic              jr_misalign_q, jr_misalign_d;

    logic [ADDR_W-1:0] pc4;
    logic              redir_req;
    logic [ADDR_W-1:0] redir_tgt;
    logic              jr_bad;

    assign pc4 = pc_q + ADDR_W'(4);

    // Redirect source below the exception, in priority order jr > j > branch.
    always_comb begin
        redir_req = jr_req | j_req | br_taken;
        redir_tgt = pc4;
        if (jr_req) begin
            redir_tgt = r_target(jr_target);
        end else if (j_req) begin
            redir_tgt = j_target(pc4, j_index);
        end else if (br_taken) begin
            redir_tgt = b_target(pc4, br_offset);
        end
        jr_bad = jr_req && (jr_target[1:0] != 2'b00);
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        tgt_d         = tgt_q;
        jr_misalign_d = 1'b0;
        if (en) begin
            unique case (state_q)
                RUN: begin
                    if (exc_req) begin
                        pc_d = EXC_PC;
                    end else if (redir_req) begin
                        jr_misalign_d = jr_bad;
                        if (DELAY_SLOT != 0) begin
                            tgt_d   = redir_tgt;
                            pc_d    = pc4;
                            state_d = SLOT;
                        end else begin
                            pc_d = redir_tgt;
                        end
                    end else begin
                        pc_d = pc4;
                    end
                end
                SLOT: begin
                    // Requests from the delay-slot instruction itself are not honoured.
                    pc_d    = exc_req ? EXC_PC : tgt_q;
                    tgt_d   = '0;
                    state_d = RUN;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            pc_q          <= RST_PC;
            tgt_q         <= '0;
            jr_misalign_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            tgt_q         <= tgt_d;
            jr_misalign_q <= jr_misalign_d;
        end
    end

    assign pc           = pc_q;
    assign pc_plus4     = pc4;
    assign slot_pending = (state_q == SLOT);
    assign jr_misalign  = jr_misalign_q;

endmodule

// File: tb/tb_npc_gen.sv
// Bench for npc_gen: table of immediate-redirect vectors, delay-slot sequences,
// and randomized traffic on three configurations against an arithmetic model.
module tb_npc_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b1;
    logic        br_taken = 1'b0;
    logic [15:0] br_offset = '0;
    logic        j_req = 1'b0;
    logic [25:0] j_index = '0;
    logic        jr_req = 1'b0;
    logic [31:0] jr_target = '0;
    logic [39:0] jr_target_w = '0;
    logic        exc_req = 1'b0;

    logic [31:0] pc0, pp0, pc1, pp1;
    logic [39:0] pc2, pp2;
    logic        sp0, mis0, sp1, mis1, sp2, mis2;

    int nvec = 0;
    int nerr = 0;

    npc_gen #(.ADDR_W(32), .DELAY_SLOT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .br_taken(br_taken), .br_offset(br_offset),
        .j_req(j_req), .j_index(j_index), .jr_req(jr_req), .jr_target(jr_target),
        .exc_req(exc_req), .pc(pc0), .pc_plus4(pp0), .slot_pending(sp0), .jr_misalign(mis0));

    npc_gen #(.ADDR_W(32), .DELAY_SLOT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .br_taken(br_taken), .br_offset(br_offset),
        .j_req(j_req), .j_index(j_index), .jr_req(jr_req), .jr_target(jr_target),
        .exc_req(exc_req), .pc(pc1), .pc_plus4(pp1), .slot_pending(sp1), .jr_misalign(mis1));

    npc_gen #(.ADDR_W(40), .DELAY_SLOT(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .br_taken(br_taken), .br_offset(br_offset),
        .j_req(j_req), .j_index(j_index), .jr_req(jr_req), .jr_target(jr_target_w),
        .exc_req(exc_req), .pc(pc2), .pc_plus4(pp2), .slot_pending(sp2), .jr_misalign(mis2));

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] tgt;
        bit          slot;
        bit          mis;
    } mstate_t;

    mstate_t m[3];
    int      mw[3]  = '{32, 32, 40};
    bit      mds[3] = '{1'b0, 1'b1, 1'b0};

    function automatic logic [63:0] wmask(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    // Next architectural state from the current inputs, in plain arithmetic.
    function automatic mstate_t mstep(input mstate_t s, input bit ds, input int w,
                                      input logic [63:0] jrt);
        mstate_t     n;
        logic [63:0] mk, nx4, t, off64;
        n     = s;
        n.mis = 1'b0;
        if (!en) return n;
        mk  = wmask(w);
        nx4 = (s.pc + 64'd4) & mk;
        if (s.slot) begin
            n.pc   = exc_req ? 64'h0040_0004 : s.tgt;
            n.slot = 1'b0;
        end else if (exc_req) begin
            n.pc = 64'h0040_0004;
        end else if (jr_req || j_req || br_taken) begin
            if (jr_req) begin
                t     = (jrt & mk) - (jrt % 64'd4);
                n.mis = (jrt % 64'd4) != 64'd0;
            end else if (j_req) begin
                t = ((nx4 / 64'h1000_0000) * 64'h1000_0000) + 64'(j_index) * 64'd4;
            end else begin
                off64 = {{48{br_offset[15]}}, br_offset};
                t     = (nx4 + off64 * 64'd4) & mk;
            end
            if (ds) begin
                n.tgt  = t;
                n.pc   = nx4;
                n.slot = 1'b1;
            end else begin
                n.pc = t;
            end
        end else begin
            n.pc = nx4;
        end
        return n;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic compare_all();
        chk("dut0.pc",       {32'h0, pc0}, m[0].pc);
        chk("dut0.pc_plus4", {32'h0, pp0}, (m[0].pc + 64'd4) & wmask(32));
        chk("dut0.slot",     {63'h0, sp0}, {63'h0, m[0].slot});
        chk("dut0.misalign", {63'h0, mis0}, {63'h0, m[0].mis});
        chk("dut1.pc",       {32'h0, pc1}, m[1].pc);
        chk("dut1.pc_plus4", {32'h0, pp1}, (m[1].pc + 64'd4) & wmask(32));
        chk("dut1.slot",     {63'h0, sp1}, {63'h0, m[1].slot});
        chk("dut1.misalign", {63'h0, mis1}, {63'h0, m[1].mis});
        chk("dut2.pc",       {24'h0, pc2}, m[2].pc);
        chk("dut2.pc_plus4", {24'h0, pp2}, (m[2].pc + 64'd4) & wmask(40));
        chk("dut2.slot",     {63'h0, sp2}, {63'h0, m[2].slot});
        chk("dut2.misalign", {63'h0, mis2}, {63'h0, m[2].mis});
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                m[k] = mstep(m[k], mds[k], mw[k], (k == 2) ? {24'h0, jr_target_w} : {32'h0, jr_target});
            end
        end
        #1;
        compare_all();
    endtask

    task automatic idle();
        en = 1'b1; exc_req = 1'b0; jr_req = 1'b0; j_req = 1'b0; br_taken = 1'b0;
        br_offset = '0; j_index = '0; jr_target = '0; jr_target_w = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        #1;
        for (int k = 0; k < 3; k++) begin
            m[k].pc = 64'h0040_0000; m[k].tgt = '0; m[k].slot = 1'b0; m[k].mis = 1'b0;
        end
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic advance(input int n);
        idle();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic j_to_800();
        idle();
        j_req   = 1'b1;
        j_index = 26'h010_0200;
        tick();
        chk("ds1.slot_pc", {32'h0, pc1}, 64'h0040_0044);
        chk("ds1.slot_on", {63'h0, sp1}, 64'h1);
        idle();
    endtask

    typedef struct {
        bit          en;
        bit          exc;
        bit          jr;
        logic [31:0] jrt;
        bit          j;
        logic [25:0] jidx;
        bit          br;
        logic [15:0] off;
        logic [31:0] epc;
        bit          emis;
    } vec_t;

    vec_t tbl[17];

    initial begin
        tbl[0]  = '{1, 0, 0, 32'h0,          0, 26'h0,        0, 16'h0,    32'h0040_0004, 0};
        tbl[1]  = '{1, 0, 0, 32'h0,          0, 26'h0,        0, 16'h0,    32'h0040_0008, 0};
        tbl[2]  = '{1, 0, 0, 32'h0,          0, 26'h0,        0, 16'h0,    32'h0040_000C, 0};
        tbl[3]  = '{0, 0, 0, 32'h0,          0, 26'h0,        0, 16'h0,    32'h0040_000C, 0};
        tbl[4]  = '{0, 0, 0, 32'h0,          0, 26'h0,        0, 16'h0,    32'h0040_000C, 0};
        tbl[5]  = '{1, 0, 0, 32'h0,          0, 26'h0,        0, 16'h0,    32'h0040_0010, 0};
        tbl[6]  = '{1, 0, 0, 32'h0,          1, 26'h010_0040, 0, 16'h0,    32'h0040_0100, 0};
        tbl[7]  = '{1, 0, 0, 32'h0,          0, 26'h0,        1, 16'hFFFF, 32'h0040_0100, 0};
        tbl[8]  = '{1, 0, 1, 32'h0040_0020, 0, 26'h0,        0, 16'h0,    32'h0040_0020, 0};
        tbl[9]  = '{1, 1, 1, 32'h0040_1000, 0, 26'h0,        1, 16'h0010, 32'h0040_0004, 0};
        tbl[10] = '{1, 0, 1, 32'h0040_2003, 0, 26'h0,        0, 16'h0,    32'h0040_2000, 1};
        tbl[11] = '{1, 0, 0, 32'h0,          0, 26'h0,        0, 16'h0,    32'h0040_2004, 0};
        tbl[12] = '{1, 0, 1, 32'hFFFF_FFFC, 0, 26'h0,        0, 16'h0,    32'hFFFF_FFFC, 0};
        tbl[13] = '{1, 0, 0, 32'h0,          0, 26'h0,        0, 16'h0,    32'h0000_0000, 0};
        tbl[14] = '{0, 0, 1, 32'h0040_2003, 0, 26'h0,        0, 16'h0,    32'h0000_0000, 0};
        tbl[15] = '{1, 0, 0, 32'h0,          0, 26'h0,        1, 16'h0004, 32'h0000_0014, 0};
        tbl[16] = '{1, 0, 0, 32'h0,          1, 26'h000_0003, 1, 16'h0100, 32'h0000_000C, 0};

        #2;
        do_reset();
        chk("reset.pc", {32'h0, pc0}, 64'h0040_0000);

        for (int i = 0; i < 17; i++) begin
            en = tbl[i].en; exc_req = tbl[i].exc; jr_req = tbl[i].jr;
            jr_target = tbl[i].jrt; jr_target_w = {8'h00, tbl[i].jrt};
            j_req = tbl[i].j; j_index = tbl[i].jidx;
            br_taken = tbl[i].br; br_offset = tbl[i].off;
            tick();
            chk($sformatf("tbl[%0d].pc", i), {32'h0, pc0}, {32'h0, tbl[i].epc});
            chk($sformatf("tbl[%0d].pc_plus4", i), {32'h0, pp0}, {32'h0, tbl[i].epc + 32'd4});
            chk($sformatf("tbl[%0d].misalign", i), {63'h0, mis0}, {63'h0, tbl[i].emis});
        end

        // Delay slot: slot instruction then target.
        do_reset();
        advance(16);
        chk("ds1.start_pc", {32'h0, pc1}, 64'h0040_0040);
        j_to_800();
        tick();
        chk("ds1.tgt_pc", {32'h0, pc1}, 64'h0040_0800);
        chk("ds1.slot_off", {63'h0, sp1}, 64'h0);

        // Stalls inside the slot extend the latency.
        do_reset();
        advance(16);
        j_to_800();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ds1.stall_pc", {32'h0, pc1}, 64'h0040_0044);
            chk("ds1.stall_slot", {63'h0, sp1}, 64'h1);
        end
        en = 1'b1;
        tick();
        chk("ds1.stall_tgt", {32'h0, pc1}, 64'h0040_0800);

        // Exception in the slot discards the target.
        do_reset();
        advance(16);
        j_to_800();
        exc_req = 1'b1;
        tick();
        chk("ds1.exc_pc", {32'h0, pc1}, 64'h0040_0004);
        chk("ds1.exc_slot", {63'h0, sp1}, 64'h0);
        idle();
        tick();
        chk("ds1.exc_after", {32'h0, pc1}, 64'h0040_0008);

        // Asynchronous reset while the slot is pending.
        do_reset();
        advance(16);
        j_to_800();
        rst_n = 1'b0;
        #1;
        chk("ds1.rst_pc", {32'h0, pc1}, 64'h0040_0000);
        chk("ds1.rst_slot", {63'h0, sp1}, 64'h0);
        do_reset();
        tick();
        chk("ds1.rst_after", {32'h0, pc1}, 64'h0040_0004);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end
            en          = ($urandom_range(0, 99) < 85);
            exc_req     = ($urandom_range(0, 99) < 5);
            jr_req      = ($urandom_range(0, 99) < 10);
            j_req       = ($urandom_range(0, 99) < 10);
            br_taken    = ($urandom_range(0, 99) < 20);
            br_offset   = 16'($urandom);
            j_index     = 26'($urandom);
            jr_target   = $urandom;
            jr_target_w = {8'($urandom), jr_target};
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/npc_gen.md
# npc_gen

Parametrised program-counter generator for the 31-instruction MIPS CPU. It holds the PC register and computes the next PC each cycle. Sources, in priority order: exception entry, register jump (jr), J-type jump (concatenating {(PC+4) high bits, instr_index, 2'b00}), conditional branch, and sequential PC+4. An optional branch-delay-slot mode defers the redirect by one instruction. The block sits between the decode/execute logic and instruction memory, and replaces the purely combinational jump-target concatenator.

## Interface
Parameters:
- ADDR_W, 32: PC width. Legal range 28..64.
- RESET_VEC, 32'h0040_0000: PC after reset. Zero-extended or truncated to ADDR_W.
- EXC_VEC, 32'h0040_0004: exception entry address.
- DELAY_SLOT, 0: 0 = immediate redirect; 1 = MIPS delay-slot semantics.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  advance enable. When 0 (stall), all state holds and requests are ignored.
- br_taken  in  1  conditional branch resolved taken.
- br_offset  in  16  branch immediate (signed word offset).
- j_req  in  1  J/JAL request.
- j_index  in  26  instr_index field.
- jr_req  in  1  JR/JALR request.
- jr_target  in  ADDR_W  register jump target.
- exc_req  in  1  exception/syscall entry.
- pc  out  ADDR_W  current fetch address (registered).
- pc_plus4  out  ADDR_W  pc+4, combinational (link value for JAL/JALR).
- slot_pending  out  1  1 while a delayed redirect is latched.
- jr_misalign  out  1  registered, 1-cycle pulse when an accepted jr_target has bits[1:0] != 0.

## Operation
- Target arithmetic. All results are taken modulo 2^ADDR_W.
  - b_tgt = pc_plus4 + (sign_extend(br_offset) << 2).
  - j_tgt = {pc_plus4[ADDR_W-1:28], j_index, 2'b00}. This is the full ADDR_W width; no truncation of the shifted index is permitted.
  - r_tgt = {jr_target[ADDR_W-1:2], 2'b00}.
- Request priority: exc_req > jr_req > j_req > br_taken. Lower-priority requests in the same cycle are discarded.
- States: RUN, SLOT. In DELAY_SLOT=0 the FSM stays in RUN.
- RUN, en=1:
  - exc_req: pc <= EXC_VEC.
  - Other request, DELAY_SLOT=0: pc <= selected target.
  - Other request, DELAY_SLOT=1: tgt_q <= selected target (computed from the current pc); pc <= pc_plus4; go to SLOT.
  - No request: pc <= pc_plus4.
- SLOT, en=1:
  - exc_req: pc <= EXC_VEC; discard tgt_q; go to RUN.
  - Otherwise: pc <= tgt_q; go to RUN. jr/j/br requests in this cycle are ignored, since a branch in a delay slot is unsupported.
- en=0: pc, state, tgt_q hold. jr_misalign is 0.
- jr_misalign is asserted on the cycle after a jr_req is accepted (selected, en=1) with jr_target[1:0] != 0. The jump still proceeds to the aligned address.
- slot_pending = (state == SLOT).

## Timing
- Reset (async assert, sync release): pc = RESET_VEC, state = RUN, tgt_q = 0, jr_misalign = 0, slot_pending = 0.
- Redirect latency, DELAY_SLOT=0: 1 cycle. The target appears on pc at the edge after the request.
- Redirect latency, DELAY_SLOT=1: 2 enabled cycles (slot instruction, then target). Stalls between them extend the latency; slot_pending stays 1 throughout.
- Exception latency: always 1 enabled cycle, in either state.
- Reset asserted mid-SLOT: the pending target is lost and pc returns to RESET_VEC.
- Wrap-around: pc = 2^ADDR_W-4 with no request gives pc = 0.
- pc_plus4 follows pc combinationally within the same cycle.

## Test plan
- Reset/sequential: release rst_n with en=1, 3 cycles -> pc = 0x00400000, 0x00400004, 0x00400008, 0x0040000C. Hold en=0 for 2 cycles -> pc holds 0x0040000C.
- J-type and branch, DELAY_SLOT=0:
  - pc=0x00400010, j_req, j_index=0x0100040 -> next pc = 0x00400100.
  - pc=0x00400100, br_taken, br_offset=0xFFFF -> next pc = 0x00400100 (0x00400104 - 4).
- Priority: at pc=0x00400020 assert exc_req, jr_req (0x00401000) and br_taken together -> pc = 0x00400004. No jr_misalign pulse.
- JR misaligned: jr_req, jr_target=0x00402003 -> pc = 0x00402000; jr_misalign = 1 for exactly one cycle.
- Delay slot, DELAY_SLOT=1:
  - pc=0x00400040, j_req, j_index=0x0100200 -> pc sequence 0x00400044 (slot_pending=1), then 0x00400800 (slot_pending=0).
  - Repeat with en=0 for 3 cycles inside SLOT -> pc holds 0x00400044, slot_pending stays 1.
  - Repeat with exc_req during SLOT -> pc = 0x00400004, target discarded.
- Wrap and reset mid-slot:
  - pc = 0xFFFFFFFC, no request -> pc = 0x00000000.
  - Assert rst_n=0 asynchronously while slot_pending=1 -> pc = 0x00400000 immediately, slot_pending = 0, no redirect after release.
